// File: rtl/rr_mux_feeder_if.sv
// Handshake bundle between the four producers, the round-robin feeder and
// the downstream 4:1 mux stage.
interface rr_mux_feeder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] out;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  a, b, c, d, in_valid, out_ready,
        output in_ready, out, sel, out_valid
    );

    modport master (
        output a, b, c, d, in_valid, out_ready,
        input  in_ready, out, sel, out_valid
    );
endinterface

// File: rtl/rr_mux_feeder.sv
// Four-channel round-robin feeder: grants one producer per transfer and
// registers its word plus the 2-bit channel index for the downstream mux.
module rr_mux_feeder #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    rr_mux_feeder_if.slave bus
);
    logic [1:0]       r_last;
    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_sel;
    logic             r_out_valid;

    logic             w_load;
    logic             w_found;
    logic [1:0]       w_grant;
    logic [WIDTH-1:0] w_payload;
    logic [3:0]       w_ready;

    // Returns {found, index} of the first valid channel after 'last', wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!res[2] && valid[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Grant search, payload select and producer-side ready.
    always_comb begin
        w_load                 = !r_out_valid || bus.out_ready;
        {w_found, w_grant}     = rr_pick(bus.in_valid, r_last);
        case (w_grant)
            2'd0:    w_payload = bus.a;
            2'd1:    w_payload = bus.b;
            2'd2:    w_payload = bus.c;
            2'd3:    w_payload = bus.d;
            default: w_payload = {WIDTH{1'b0}};
        endcase
        if (w_load && w_found && !rst) begin
            w_ready = 4'b0001 << w_grant;
        end else begin
            w_ready = 4'b0000;
        end
    end

    // Output register and rotation pointer; only a transfer moves 'last'.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 2'd3;
            r_out       <= {WIDTH{1'b0}};
            r_sel       <= 2'd0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (w_found) begin
                r_last      <= w_grant;
                r_out       <= w_payload;
                r_sel       <= w_grant;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out       = r_out;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_rr_mux_feeder.sv
// Directed bench for rr_mux_feeder: stimulus pushes hand-computed words into a
// scoreboard queue; a monitor pops and compares on every consumed output word.
module tb_rr_mux_feeder;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [5:0] exp_q[$];

    rr_mux_feeder_if #(.WIDTH(4)) bus ();
    rr_mux_feeder #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] word, input logic [1:0] s);
        exp_q.push_back({word, s});
    endtask

    // Monitor: every word the consumer takes must match the scoreboard head.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {bus.out, bus.sel}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_out", bus.out, e[5:2]);
                    chk("sb_sel", bus.sel, e[1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rot_out [5];
        logic [1:0] rot_sel [5];
        rot_out = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1;
        bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;

        // Reset with all inputs valid.
        repeat (2) begin
            @(negedge clk);
            chk("rst_out", bus.out, 0);
            chk("rst_sel", bus.sel, 0);
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", bus.out_valid, 0);
        chk("post_rst_out", bus.out, 0);
        chk("post_rst_in_ready", bus.in_ready, 4'b0001);

        // Rotation: all channels valid, sel 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            push(rot_out[k], rot_sel[k]);
            @(posedge clk);
            @(negedge clk);
            chk("rot_valid", bus.out_valid, 1);
            chk("rot_sel", bus.sel, rot_sel[k]);
        end

        // Single channel b after last grant to channel 0.
        bus.in_valid = 4'b0010; bus.b = 4'h9;
        #1 chk("single_in_ready", bus.in_ready, 4'b0010);
        push(4'h9, 2'd1);
        @(posedge clk); @(negedge clk);
        chk("single_out", bus.out, 4'h9);
        chk("single_sel", bus.sel, 1);
        chk("single_valid", bus.out_valid, 1);
        bus.in_valid = 4'b0000;
        @(posedge clk); @(negedge clk);
        chk("single_drain", bus.out_valid, 0);

        // Skip and wrap: last = 1, channels 0 and 3 valid.
        bus.in_valid = 4'b1001;
        #1 chk("skip_in_ready", bus.in_ready, 4'b1000);
        push(4'h4, 2'd3);
        @(posedge clk); @(negedge clk);
        chk("skip_sel", bus.sel, 3);
        #1 chk("wrap_in_ready", bus.in_ready, 4'b0001);
        push(4'h1, 2'd0);
        @(posedge clk); @(negedge clk);
        chk("wrap_sel", bus.sel, 0);
        bus.in_valid = 4'b0000;
        @(posedge clk); @(negedge clk);
        chk("idle_valid", bus.out_valid, 0);

        // Backpressure: load c = 0x3 (sel 2), then stall three edges.
        bus.in_valid = 4'b0100;
        #1 chk("bp_load_in_ready", bus.in_ready, 4'b0100);
        push(4'h3, 2'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out", bus.out, 4'h3);
            chk("bp_sel", bus.sel, 2);
            chk("bp_valid", bus.out_valid, 1);
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        #1 chk("bp_release_in_ready", bus.in_ready, 4'b1000);
        push(4'h4, 2'd3);
        @(posedge clk); #1;

        // Reset mid-stream while a word is held; that word is dropped.
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_held_sel", bus.sel, 3);
        chk("mid_held_valid", bus.out_valid, 1);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b1111;
        @(negedge clk);
        chk("mid_after_valid", bus.out_valid, 0);
        chk("mid_after_sel", bus.sel, 0);
        chk("mid_first_grant", bus.in_ready, 4'b0001);
        push(4'h1, 2'd0);
        @(posedge clk); @(negedge clk);
        chk("mid_grant_sel", bus.sel, 0);
        chk("mid_grant_out", bus.out, 4'h1);
        bus.in_valid = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
